// File: rtl/morty_lsu_if.sv
// morty_lsu_if: core request and data-memory bus signals of the Morty load/store unit
interface morty_lsu_if #(parameter int XLEN = 32);
  localparam int W = XLEN / 8;
  logic            req_i;
  logic            we_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] addr_i;
  logic [XLEN-1:0] wdata_i;
  logic            ready_o;
  logic            done_o;
  logic [XLEN-1:0] rdata_o;
  logic            misaligned_o;
  logic            illegal_o;
  logic            bus_err_o;
  logic            mem_cyc_o;
  logic            mem_we_o;
  logic [XLEN-1:0] mem_addr_o;
  logic [W-1:0]    mem_sel_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic [XLEN-1:0] mem_rdata_i;
  logic            mem_ack_i;
  logic            mem_err_i;
  modport slave (
    input  req_i, we_i, funct3_i, addr_i, wdata_i, mem_rdata_i, mem_ack_i, mem_err_i,
    output ready_o, done_o, rdata_o, misaligned_o, illegal_o, bus_err_o,
    output mem_cyc_o, mem_we_o, mem_addr_o, mem_sel_o, mem_wdata_o
  );
  modport master (
    output req_i, we_i, funct3_i, addr_i, wdata_i, mem_rdata_i, mem_ack_i, mem_err_i,
    input  ready_o, done_o, rdata_o, misaligned_o, illegal_o, bus_err_o,
    input  mem_cyc_o, mem_we_o, mem_addr_o, mem_sel_o, mem_wdata_o
  );
endinterface

// File: rtl/morty_lsu.sv
// morty_lsu: load/store unit with byte-lane steering and optional two-beat misaligned split
module morty_lsu #(
  parameter int XLEN        = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input logic       clk_i,
  input logic       rst_ni,
  morty_lsu_if.slave bus
);
  localparam int W  = XLEN / 8;
  localparam int OB = $clog2(W);
  localparam int NB = OB + 2;
  typedef enum logic [2:0] {IDLE, BEAT0, GAP, BEAT1, RESP} state_t;
  state_t          r_state, w_next;
  logic            r_we, r_mis, r_ill, r_err;
  logic [2:0]      r_f3;
  logic [XLEN-1:0] r_addr, r_wdata, r_rd0, r_rdata;
  logic [NB-1:0]   w_in_n, w_n;
  logic            w_in_ill, w_in_mis, w_cross, w_cyc, w_b1, w_neg;
  logic [OB-1:0]   w_off;
  logic [W-1:0]    w_bm;
  logic [2*W-1:0]  w_sel2;
  logic [2*XLEN-1:0] w_wd2;
  logic [XLEN-1:0] w_base, w_lo, w_hi, w_raw, w_keep, w_top, w_load;
  assign w_in_n   = NB'(1) << bus.funct3_i[1:0];
  assign w_in_ill = (bus.funct3_i == 3'b111) || (bus.we_i && bus.funct3_i[2]) ||
                    (XLEN == 32 && (bus.funct3_i[1:0] == 2'b11 || bus.funct3_i == 3'b110));
  assign w_in_mis = !MISALIGN_EN && |({2'b00, bus.addr_i[OB-1:0]} & (w_in_n - NB'(1)));
  assign w_off    = r_addr[OB-1:0];
  assign w_n      = NB'(1) << r_f3[1:0];
  assign w_cross  = ({2'b00, w_off} + w_n) > NB'(W);
  assign w_bm     = ~({W{1'b1}} << w_n);
  assign w_sel2   = {{W{1'b0}}, w_bm} << w_off;
  assign w_wd2    = {{XLEN{1'b0}}, r_wdata} << {w_off, 3'b000};
  assign w_base   = {r_addr[XLEN-1:OB], {OB{1'b0}}};
  assign w_cyc    = r_state == BEAT0 || r_state == BEAT1;
  assign w_b1     = r_state == BEAT1;
  assign w_lo     = w_b1 ? r_rd0 : bus.mem_rdata_i;
  assign w_hi     = w_b1 ? bus.mem_rdata_i : '0;
  assign w_raw    = XLEN'({w_hi, w_lo} >> {w_off, 3'b000});
  assign w_keep   = ~({XLEN{1'b1}} << {w_n, 3'b000});
  assign w_top    = w_keep & ~(w_keep >> 1);
  assign w_neg    = !r_f3[2] && |(w_raw & w_top);
  assign w_load   = (w_raw & w_keep) | (w_neg ? ~w_keep : '0);
  assign bus.mem_cyc_o    = w_cyc;
  assign bus.mem_we_o     = w_cyc && r_we;
  assign bus.mem_addr_o   = !w_cyc ? '0 : w_b1 ? w_base + XLEN'(W) : w_base;
  assign bus.mem_sel_o    = !w_cyc ? '0 : w_b1 ? w_sel2[2*W-1:W] : w_sel2[W-1:0];
  assign bus.mem_wdata_o  = !w_cyc ? '0 : w_b1 ? w_wd2[2*XLEN-1:XLEN] : w_wd2[XLEN-1:0];
  assign bus.ready_o      = r_state == IDLE;
  assign bus.done_o       = r_state == RESP;
  assign bus.rdata_o      = r_rdata;
  assign bus.misaligned_o = r_mis;
  assign bus.illegal_o    = r_ill;
  assign bus.bus_err_o    = r_err;
  // next state: faulting requests skip the bus, a word-crossing first beat inserts an idle gap
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = !bus.req_i ? IDLE : (w_in_ill || w_in_mis) ? RESP : BEAT0;
      BEAT0:   w_next = bus.mem_err_i ? RESP : !bus.mem_ack_i ? BEAT0 : w_cross ? GAP : RESP;
      GAP:     w_next = BEAT1;
      BEAT1:   w_next = (bus.mem_err_i || bus.mem_ack_i) ? RESP : BEAT1;
      default: w_next = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  end
  // request capture, first-beat read data, and results latched on entry to RESP
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_we    <= 1'b0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd0   <= '0;
      r_rdata <= '0;
      r_mis   <= 1'b0;
      r_ill   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == IDLE && bus.req_i) begin
        r_we    <= bus.we_i;
        r_f3    <= bus.funct3_i;
        r_addr  <= bus.addr_i;
        r_wdata <= bus.wdata_i;
      end
      if (r_state == BEAT0 && bus.mem_ack_i) r_rd0 <= bus.mem_rdata_i;
      if (w_next == RESP && r_state != RESP) begin
        r_rdata <= (r_state != IDLE && !bus.mem_err_i && !r_we) ? w_load : '0;
        r_ill   <= r_state == IDLE && w_in_ill;
        r_mis   <= r_state == IDLE && !w_in_ill && w_in_mis;
        r_err   <= r_state != IDLE && bus.mem_err_i;
      end
    end
  end
endmodule

// File: tb/tb_morty_lsu.sv
// tb_morty_lsu: directed checks of the load/store unit in 32-bit split, 32-bit strict and 64-bit builds
module tb_morty_lsu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  morty_lsu_if #(.XLEN(32)) a();
  morty_lsu_if #(.XLEN(32)) b();
  morty_lsu_if #(.XLEN(64)) c();
  morty_lsu #(.XLEN(32), .MISALIGN_EN(1'b1)) u_a (.clk_i(clk), .rst_ni(rst_n), .bus(a.slave));
  morty_lsu #(.XLEN(32), .MISALIGN_EN(1'b0)) u_b (.clk_i(clk), .rst_ni(rst_n), .bus(b.slave));
  morty_lsu #(.XLEN(64), .MISALIGN_EN(1'b1)) u_c (.clk_i(clk), .rst_ni(rst_n), .bus(c.slave));
  task automatic chk(input string t, input logic [63:0] o, input logic [63:0] e);
    checks++;
    if (o !== e) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, e);
    end
  endtask
  task automatic go_a(input logic we, input logic [2:0] f3, input logic [31:0] ad, input logic [31:0] wd);
    @(negedge clk);
    a.req_i = 1'b1; a.we_i = we; a.funct3_i = f3; a.addr_i = ad; a.wdata_i = wd;
    @(negedge clk);
    a.req_i = 1'b0;
  endtask
  task automatic beat_a(input logic e, input logic [31:0] d);
    a.mem_ack_i = !e; a.mem_err_i = e; a.mem_rdata_i = d;
    @(negedge clk);
    a.mem_ack_i = 1'b0; a.mem_err_i = 1'b0;
  endtask
  task automatic go_b(input logic [2:0] f3, input logic [31:0] ad);
    @(negedge clk);
    b.req_i = 1'b1; b.we_i = 1'b0; b.funct3_i = f3; b.addr_i = ad; b.wdata_i = '0;
    @(negedge clk);
    b.req_i = 1'b0;
  endtask
  task automatic go_c(input logic [2:0] f3, input logic [63:0] ad);
    @(negedge clk);
    c.req_i = 1'b1; c.we_i = 1'b0; c.funct3_i = f3; c.addr_i = ad; c.wdata_i = '0;
    @(negedge clk);
    c.req_i = 1'b0;
  endtask
  task automatic beat_c(input logic [63:0] d);
    c.mem_ack_i = 1'b1; c.mem_rdata_i = d;
    @(negedge clk);
    c.mem_ack_i = 1'b0;
  endtask
  initial begin
    a.req_i = 1'b0; a.we_i = 1'b0; a.funct3_i = '0; a.addr_i = '0; a.wdata_i = '0;
    a.mem_rdata_i = '0; a.mem_ack_i = 1'b0; a.mem_err_i = 1'b0;
    b.req_i = 1'b0; b.we_i = 1'b0; b.funct3_i = '0; b.addr_i = '0; b.wdata_i = '0;
    b.mem_rdata_i = '0; b.mem_ack_i = 1'b0; b.mem_err_i = 1'b0;
    c.req_i = 1'b0; c.we_i = 1'b0; c.funct3_i = '0; c.addr_i = '0; c.wdata_i = '0;
    c.mem_rdata_i = '0; c.mem_ack_i = 1'b0; c.mem_err_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", a.ready_o, 1'b1);
    chk("rst_done", a.done_o, 1'b0);
    chk("rst_cyc", a.mem_cyc_o, 1'b0);
    chk("rst_rdata", a.rdata_o, 32'h0);
    chk("rst_sel", a.mem_sel_o, 4'h0);
    rst_n = 1'b1;
    go_a(1'b0, 3'b010, 32'h100, 32'h0);
    chk("lw_cyc", a.mem_cyc_o, 1'b1);
    chk("lw_addr", a.mem_addr_o, 32'h100);
    chk("lw_sel", a.mem_sel_o, 4'hF);
    chk("lw_busy", a.ready_o, 1'b0);
    @(negedge clk);
    chk("lw_hold", a.mem_cyc_o, 1'b1);
    beat_a(1'b0, 32'hDEADBEEF);
    chk("lw_done", a.done_o, 1'b1);
    chk("lw_rdata", a.rdata_o, 32'hDEADBEEF);
    chk("lw_cyc_off", a.mem_cyc_o, 1'b0);
    @(negedge clk);
    chk("lw_pulse", a.done_o, 1'b0);
    chk("lw_ready", a.ready_o, 1'b1);
    chk("lw_keep", a.rdata_o, 32'hDEADBEEF);
    go_a(1'b0, 3'b000, 32'h103, 32'h0);
    chk("lb_addr", a.mem_addr_o, 32'h100);
    chk("lb_sel", a.mem_sel_o, 4'h8);
    beat_a(1'b0, 32'h80FFFFFF);
    chk("lb_rdata", a.rdata_o, 32'hFFFFFF80);
    go_a(1'b0, 3'b100, 32'h103, 32'h0);
    beat_a(1'b0, 32'h80FFFFFF);
    chk("lbu_rdata", a.rdata_o, 32'h00000080);
    go_a(1'b1, 3'b010, 32'h102, 32'h12345678);
    chk("sw_b0_addr", a.mem_addr_o, 32'h100);
    chk("sw_b0_sel", a.mem_sel_o, 4'hC);
    chk("sw_b0_wdata", a.mem_wdata_o, 32'h56780000);
    chk("sw_b0_we", a.mem_we_o, 1'b1);
    beat_a(1'b0, 32'h0);
    chk("sw_gap_cyc", a.mem_cyc_o, 1'b0);
    chk("sw_gap_done", a.done_o, 1'b0);
    @(negedge clk);
    chk("sw_b1_addr", a.mem_addr_o, 32'h104);
    chk("sw_b1_sel", a.mem_sel_o, 4'h3);
    chk("sw_b1_wdata", a.mem_wdata_o, 32'h00001234);
    beat_a(1'b0, 32'h0);
    chk("sw_done", a.done_o, 1'b1);
    go_a(1'b0, 3'b001, 32'h103, 32'h0);
    beat_a(1'b0, 32'hAB000000);
    @(negedge clk);
    chk("lh_b1_addr", a.mem_addr_o, 32'h104);
    chk("lh_b1_sel", a.mem_sel_o, 4'h1);
    beat_a(1'b0, 32'h000000CD);
    chk("lh_rdata", a.rdata_o, 32'hFFFFCDAB);
    go_a(1'b0, 3'b101, 32'h103, 32'h0);
    beat_a(1'b0, 32'hAB000000);
    @(negedge clk);
    beat_a(1'b0, 32'h000000CD);
    chk("lhu_rdata", a.rdata_o, 32'h0000CDAB);
    go_a(1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000BEEF);
    chk("wrap_b0_addr", a.mem_addr_o, 32'hFFFFFFFC);
    chk("wrap_b0_sel", a.mem_sel_o, 4'h8);
    chk("wrap_b0_wdata", a.mem_wdata_o, 32'hEF000000);
    beat_a(1'b0, 32'h0);
    @(negedge clk);
    chk("wrap_b1_addr", a.mem_addr_o, 32'h0);
    chk("wrap_b1_sel", a.mem_sel_o, 4'h1);
    chk("wrap_b1_wdata", a.mem_wdata_o, 32'h000000BE);
    beat_a(1'b0, 32'h0);
    chk("wrap_done", a.done_o, 1'b1);
    chk("wrap_rdata", a.rdata_o, 32'h0);
    go_a(1'b1, 3'b010, 32'h103, 32'hCAFEF00D);
    beat_a(1'b1, 32'h0);
    chk("err_done", a.done_o, 1'b1);
    chk("err_flag", a.bus_err_o, 1'b1);
    chk("err_cyc", a.mem_cyc_o, 1'b0);
    @(negedge clk);
    chk("err_nobeat1", a.mem_cyc_o, 1'b0);
    chk("err_ready", a.ready_o, 1'b1);
    chk("err_keep", a.bus_err_o, 1'b1);
    go_a(1'b0, 3'b011, 32'h100, 32'h0);
    chk("ld32_done", a.done_o, 1'b1);
    chk("ld32_illegal", a.illegal_o, 1'b1);
    chk("ld32_cyc", a.mem_cyc_o, 1'b0);
    chk("ld32_err_clr", a.bus_err_o, 1'b0);
    go_a(1'b1, 3'b100, 32'h100, 32'h0);
    chk("sbu_illegal", a.illegal_o, 1'b1);
    go_b(3'b010, 32'h101);
    chk("mis_done", b.done_o, 1'b1);
    chk("mis_flag", b.misaligned_o, 1'b1);
    chk("mis_cyc", b.mem_cyc_o, 1'b0);
    go_b(3'b001, 32'h102);
    chk("strict_lh_cyc", b.mem_cyc_o, 1'b1);
    chk("strict_lh_sel", b.mem_sel_o, 4'hC);
    go_c(3'b110, 64'h100C);
    chk("lwu64_addr", c.mem_addr_o, 64'h1008);
    chk("lwu64_sel", c.mem_sel_o, 8'hF0);
    beat_c(64'h80000000_12345678);
    chk("lwu64_rdata", c.rdata_o, 64'h00000000_80000000);
    go_c(3'b010, 64'h100C);
    beat_c(64'h80000000_12345678);
    chk("lw64_rdata", c.rdata_o, 64'hFFFFFFFF_80000000);
    go_c(3'b011, 64'h10);
    beat_c(64'h8123456789ABCDEF);
    chk("ld64_rdata", c.rdata_o, 64'h8123456789ABCDEF);
    go_a(1'b1, 3'b010, 32'h102, 32'h12345678);
    beat_a(1'b0, 32'h0);
    @(negedge clk);
    chk("rstb1_cyc", a.mem_cyc_o, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstb1_cyc_drop", a.mem_cyc_o, 1'b0);
    chk("rstb1_ready", a.ready_o, 1'b1);
    chk("rstb1_addr", a.mem_addr_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", a.mem_cyc_o, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
